// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch stage feeding a single-cycle CPU core. It owns the
// architectural PC and a word-addressed instruction memory whose read takes
// MEM_LAT cycles. Each fetched instruction is offered with a valid/ready
// handshake. The core can redirect the PC at any time, and any in-flight
// fetch is then dropped. The memory is loaded through a separate write port.
//
// Ports
//   i_clk             clock, all state changes on the rising edge
//   i_rst             synchronous active-high reset
//   i_load_en         instruction memory write enable
//   i_load_addr       word index for the memory write
//   i_load_data       instruction word to write
//   i_redirect_valid  core requests a PC change this cycle
//   i_redirect_pc     absolute target byte address (bits [1:0] ignored)
//   o_inst_valid      o_inst_out/o_pc_out hold a valid instruction
//   i_inst_ready      core consumes the instruction this cycle
//   o_inst_out        fetched instruction word
//   o_pc_out          byte address that o_inst_out was read from
//   o_busy            fetch in flight
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned MEM_LAT   = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_load_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_load_addr,
  input  logic [31:0]                  i_load_data,
  input  logic                         i_redirect_valid,
  input  logic [PC_W-1:0]              i_redirect_pc,
  output logic                         o_inst_valid,
  input  logic                         i_inst_ready,
  output logic [31:0]                  o_inst_out,
  output logic [PC_W-1:0]              o_pc_out,
  output logic                         o_busy
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  // One extra count value so the counter can step past MEM_LAT-1 on capture.
  localparam int unsigned LW = $clog2(MEM_LAT + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [LW-1:0]   r_lat_cnt;
  logic [LW-1:0]   w_lat_cnt_nxt;
  logic [31:0]     r_inst;
  logic [PC_W-1:0] r_pc_out;

  logic [31:0]     r_mem [MEM_DEPTH];

  logic [AW-1:0]   w_rd_idx;
  logic            w_lat_done;
  logic            w_handshake;
  logic            w_capture;

  // Upper PC bits are ignored, so fetch wraps modulo MEM_DEPTH words.
  assign w_rd_idx   = r_pc[AW+1:2];
  assign w_lat_done = (r_lat_cnt == LAT_LAST);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic. A redirect overrides every state transition.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (i_redirect_valid) begin
      w_state_nxt = StFetch;
    end else begin
      unique case (r_state)
        StIdle:  w_state_nxt = StFetch;
        StFetch: if (w_lat_done) w_state_nxt = StHold;
        StHold:  if (i_inst_ready) w_state_nxt = StFetch;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and datapath strobes
  // -------------------------------------------------------------------------
  always_comb begin
    o_inst_valid = 1'b0;
    o_busy       = 1'b0;
    unique case (r_state)
      StFetch: o_busy       = 1'b1;
      StHold:  o_inst_valid = 1'b1;
      default: ;
    endcase
    w_handshake = o_inst_valid & i_inst_ready;
    // A redirect on the final latency cycle discards the wrong-path word.
    w_capture   = o_busy & w_lat_done & ~i_redirect_valid;
  end

  // -------------------------------------------------------------------------
  // PC and latency counter next values
  // -------------------------------------------------------------------------
  always_comb begin
    w_pc_nxt = r_pc;
    if (i_redirect_valid) begin
      // A handshake in the same cycle still consumes the instruction, but
      // the redirect target replaces PC+4.
      w_pc_nxt = i_redirect_pc & ~PC_W'(3);
    end else if (w_handshake) begin
      w_pc_nxt = r_pc + PC_W'(4);
    end
  end

  always_comb begin
    w_lat_cnt_nxt = '0;
    if ((r_state == StFetch) && !i_redirect_valid) begin
      w_lat_cnt_nxt = r_lat_cnt + LW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc      <= '0;
      r_lat_cnt <= '0;
      r_inst    <= '0;
      r_pc_out  <= '0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      if (w_capture) begin
        // Reads the pre-write word if a load hits this index on the same edge.
        r_inst   <= r_mem[w_rd_idx];
        r_pc_out <= r_pc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Instruction memory, deliberately not cleared by reset
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_load_en) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  assign o_inst_out = r_inst;
  assign o_pc_out   = r_pc_out;

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the single-cycle CPU core.
- Owns the architectural PC and an internal word-addressed instruction memory with configurable read latency.
- Delivers one instruction plus its PC per valid/ready handshake.
- Accepts absolute redirect targets (jump/branch) resolved by the core and discards wrong-path fetches.
- Memory is preloaded through a write port before or during operation.

Parameters:
PC_W, 32, width of PC and redirect target.
MEM_DEPTH, 64, instruction memory depth in 32-bit words (power of 2).
MEM_LAT, 2, instruction memory read latency in cycles (>=1).

Ports:
clk  input  1  clock; all state changes on posedge clk.
rst  input  1  synchronous active-high reset, sampled on posedge clk.
load_en  input  1  write enable for instruction memory.
load_addr  input  log2(MEM_DEPTH)  word index for memory write.
load_data  input  32  instruction word to write.
redirect_valid  input  1  core requests PC change this cycle.
redirect_pc  input  PC_W  absolute target byte address.
inst_valid  output  1  inst_out/pc_out hold a valid fetched instruction.
inst_ready  input  1  core consumes the instruction this cycle.
inst_out  output  32  fetched instruction word.
pc_out  output  PC_W  byte address of inst_out.
busy  output  1  fetch in flight (state FETCH).

Behaviour:
- Reset (rst=1 at posedge):
  - PC<=0, state<=IDLE, lat_cnt<=0.
  - inst_valid=0, inst_out=0, pc_out=0, busy=0.
  - Memory contents are not cleared.
  - Reset mid-fetch or mid-HOLD aborts immediately; the held instruction is lost.
- States: IDLE, FETCH, HOLD.
  - IDLE: one cycle after reset, then -> FETCH with lat_cnt<=0.
  - FETCH: busy=1, inst_valid=0; lat_cnt increments each cycle.
    - When lat_cnt==MEM_LAT-1: capture mem[PC[log2(MEM_DEPTH)+1:2]] into inst_out and PC into pc_out, then -> HOLD.
    - First instruction is valid MEM_LAT+1 cycles after reset deasserts.
  - HOLD: inst_valid=1; inst_out/pc_out stable until handshake.
    - inst_valid&inst_ready: PC<=PC+4, -> FETCH, lat_cnt<=0.
    - Otherwise remain in HOLD indefinitely.
- Throughput: one instruction per MEM_LAT+1 cycles with inst_ready held high.
- Redirect (highest priority after rst), any state:
  - PC<=redirect_pc with bits[1:0] forced to 0.
  - -> FETCH with lat_cnt<=0; any in-flight fetch is discarded.
  - inst_valid drops to 0 the next cycle.
  - Redirect in IDLE takes effect normally.
- Redirect and handshake in the same cycle: the handshake completes (instruction consumed), but the next PC is redirect_pc, not PC+4.
- Back-to-back redirects: the last one wins; each restarts the latency count.
- Address mapping:
  - Word index = PC[log2(MEM_DEPTH)+1:2]; upper PC bits are ignored, so fetch wraps modulo MEM_DEPTH words.
  - PC itself wraps modulo 2^PC_W.
- Memory write:
  - The write commits at posedge when load_en=1.
  - A fetch capturing the same index in the same cycle returns the old word; write-before-read does not apply.
  - Writes never disturb state, PC or handshake.
- pc_out always equals the address the instruction was read from, including after redirects.

Test Plan:
- Reset, then preload mem[0..3]=0x11,0x22,0x33,0x44; rst deasserted, inst_ready=1, MEM_LAT=2 -> inst_valid first high 3 cycles after reset; stream 0x11/pc0, 0x22/pc4, 0x33/pc8, 0x44/pc12, each 3 cycles apart.
- Backpressure: hold inst_ready=0 for 5 cycles while inst_valid=1 -> inst_out/pc_out unchanged, PC not advanced; raise inst_ready -> next fetch targets pc+4.
- Redirect mid-FETCH: redirect_pc=0x0000_0023 -> wrong-path instruction never appears; next valid is pc_out=0x20 with inst_out=mem[8] after MEM_LAT cycles.
- Simultaneous handshake and redirect to 0x40 while holding pc 0x8 -> pc 0x8 consumed once; next pc_out=0x40, not 0xC.
- Wrap: MEM_DEPTH=64, redirect to 0xFC then accept -> pc_out=0xFC reads mem[63]; next pc_out=0x100 reads mem[0].
- Reset asserted while in HOLD with inst_valid=1 -> next cycle inst_valid=0, pc_out=0, busy=0; refetch from pc 0 preserves preloaded memory contents.
